// File: rtl/uart_trig_ctrl.sv
// UART trigger control: holds receiver configuration, qualifies UARTtrig matches
// against a programmable occurrence count with optional holdoff, emits one trig pulse.
module uart_trig_ctrl #(
  parameter logic [15:0] BAUD_RST = 16'd5208,
  parameter logic [7:0]  MASK_RST = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [2:0]  addr,
  input  logic [7:0]  wdata,
  input  logic        arm,
  input  logic        disarm,
  input  logic        UARTtrig,
  output logic [15:0] baud_cnt,
  output logic [7:0]  match,
  output logic [7:0]  mask,
  output logic        armed,
  output logic        triggered,
  output logic        trig,
  output logic [7:0]  match_cnt,
  output logic        wr_rej
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned HOLD_W = 16;

  typedef enum logic [1:0] {
    DISARMED  = 2'd0,
    ARMED     = 2'd1,
    HOLDOFF   = 2'd2,
    TRIGGERED = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    target;
  logic [HOLD_W-1:0]   holdoff;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [CNT_W-1:0]    match_cnt_nxt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W-1:0]    eff_target;
  logic                trig_nxt;
  logic                cfg_open;

  // Configuration is only writable while no acquisition is in progress
  assign cfg_open   = (state == DISARMED) || (state == TRIGGERED);
  assign cnt_inc    = (match_cnt == 8'hFF) ? match_cnt : match_cnt + CNT_W'(1);
  assign eff_target = (target == '0) ? CNT_W'(1) : target;

  // Configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match    <= 8'h00;
      mask     <= MASK_RST;
      baud_cnt <= BAUD_RST;
      target   <= 8'd1;
      holdoff  <= 16'd0;
    end else if (wrt && cfg_open) begin
      case (addr)
        3'd0:    match          <= wdata;
        3'd1:    mask           <= wdata;
        3'd2:    baud_cnt[7:0]  <= wdata;
        3'd3:    baud_cnt[15:8] <= wdata;
        3'd4:    target         <= wdata;
        3'd5:    holdoff[7:0]   <= wdata;
        3'd6:    holdoff[15:8]  <= wdata;
        default: ;
      endcase
    end
  end

  // State and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DISARMED;
      hold_cnt  <= '0;
      match_cnt <= '0;
      trig      <= 1'b0;
      armed     <= 1'b0;
      triggered <= 1'b0;
      wr_rej    <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      match_cnt <= match_cnt_nxt;
      trig      <= trig_nxt;
      armed     <= (state_nxt == ARMED) || (state_nxt == HOLDOFF);
      triggered <= (state_nxt == TRIGGERED);
      wr_rej    <= wrt && !cfg_open && (addr != 3'd7);
    end
  end

  // Next-state logic; disarm overrides everything
  always_comb begin
    state_nxt     = state;
    hold_cnt_nxt  = hold_cnt;
    match_cnt_nxt = match_cnt;
    trig_nxt      = 1'b0;
    if (disarm) begin
      state_nxt = DISARMED;
    end else begin
      case (state)
        DISARMED, TRIGGERED: begin
          if (arm) begin
            state_nxt     = ARMED;
            match_cnt_nxt = '0;
          end
        end
        ARMED: begin
          if (UARTtrig) begin
            match_cnt_nxt = cnt_inc;
            if (cnt_inc >= eff_target) begin
              state_nxt = TRIGGERED;
              trig_nxt  = 1'b1;
            end else if (holdoff != '0) begin
              state_nxt    = HOLDOFF;
              hold_cnt_nxt = holdoff;
            end
          end
        end
        HOLDOFF: begin
          if (hold_cnt <= HOLD_W'(1)) begin
            state_nxt    = ARMED;
            hold_cnt_nxt = '0;
          end else begin
            hold_cnt_nxt = hold_cnt - HOLD_W'(1);
          end
        end
        default: state_nxt = DISARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_trig_ctrl.sv
// Bench for uart_trig_ctrl: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the trigger qualifier.
module tb_uart_trig_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt, arm, disarm, UARTtrig;
  logic [2:0]  addr;
  logic [7:0]  wdata;
  logic [15:0] baud_cnt;
  logic [7:0]  match, mask, match_cnt;
  logic        armed, triggered, trig, wr_rej;

  int n_tests = 0;
  int n_fail  = 0;

  uart_trig_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wrt(wrt), .addr(addr), .wdata(wdata),
    .arm(arm), .disarm(disarm), .UARTtrig(UARTtrig),
    .baud_cnt(baud_cnt), .match(match), .mask(mask), .armed(armed),
    .triggered(triggered), .trig(trig), .match_cnt(match_cnt), .wr_rej(wr_rej)
  );

  always #5 clk = ~clk;

  // Reference model: acquisition flags plus a holdoff countdown in cycles
  logic [7:0]  e_match, e_mask, e_target, e_cnt;
  logic [15:0] e_baud, e_holdoff;
  bit          e_armed, e_fired, e_trig, e_rej;
  int          hold_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_match = 8'h00; e_mask = 8'hFF; e_baud = 16'd5208;
    e_target = 8'd1; e_holdoff = 16'd0; e_cnt = 8'd0;
    e_armed = 0; e_fired = 0; e_trig = 0; e_rej = 0; hold_left = 0;
  endtask

  task automatic model_step(input bit w, input logic [2:0] a, input logic [7:0] d,
                            input bit ar, input bit da, input bit u);
    int tgt;
    e_trig = 0;
    e_rej  = w && e_armed && (a != 3'd7);
    tgt    = (e_target == 0) ? 1 : int'(e_target);
    if (w && !e_armed) begin
      case (a)
        3'd0: e_match = d;
        3'd1: e_mask = d;
        3'd2: e_baud[7:0] = d;
        3'd3: e_baud[15:8] = d;
        3'd4: e_target = d;
        3'd5: e_holdoff[7:0] = d;
        3'd6: e_holdoff[15:8] = d;
        default: ;
      endcase
    end
    if (da) begin
      e_armed = 0; e_fired = 0; hold_left = 0;
    end else if (ar && !e_armed) begin
      e_armed = 1; e_fired = 0; e_cnt = 0; hold_left = 0;
    end else if (e_armed && hold_left > 0) begin
      hold_left--;
    end else if (e_armed && u) begin
      if (e_cnt != 8'hFF) e_cnt++;
      if (int'(e_cnt) >= tgt) begin
        e_armed = 0; e_fired = 1; e_trig = 1;
      end else begin
        hold_left = int'(e_holdoff);
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".baud"}, 32'(baud_cnt), 32'(e_baud));
    check({tag, ".match"}, 32'(match), 32'(e_match));
    check({tag, ".mask"}, 32'(mask), 32'(e_mask));
    check({tag, ".armed"}, 32'(armed), 32'(e_armed));
    check({tag, ".triggered"}, 32'(triggered), 32'(e_fired));
    check({tag, ".trig"}, 32'(trig), 32'(e_trig));
    check({tag, ".cnt"}, 32'(match_cnt), 32'(e_cnt));
    check({tag, ".wr_rej"}, 32'(wr_rej), 32'(e_rej));
  endtask

  // One clock: drive inputs, step the model on the edge, check just after it
  task automatic cyc(input string tag, input bit w, input logic [2:0] a, input logic [7:0] d,
                     input bit ar, input bit da, input bit u);
    wrt = w; addr = a; wdata = d; arm = ar; disarm = da; UARTtrig = u;
    @(posedge clk);
    model_step(w, a, d, ar, da, u);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 3'd0, 8'd0, 0, 0, 0);
  endtask

  task automatic wr(input string tag, input logic [2:0] a, input logic [7:0] d);
    cyc(tag, 1, a, d, 0, 0, 0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wrt = 0; addr = '0; wdata = '0; arm = 0; disarm = 0; UARTtrig = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Baud byte halves
    wr("baud_lo", 3'd2, 8'h10);
    wr("baud_hi", 3'd3, 8'h01);
    check("baud_0110", 32'(baud_cnt), 32'h0110);

    // Three counted matches, no holdoff
    wr("t3", 3'd4, 8'd3); wr("h0", 3'd5, 8'd0); wr("h1", 3'd6, 8'd0);
    cyc("arm3", 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc("m3", 0, 0, 0, 0, 0, 1);
      idle("gap3", 2);
    end
    check("tgt3_triggered", 32'(triggered), 32'd1);
    cyc("m4", 0, 0, 0, 0, 0, 1);
    check("tgt3_cnt_held", 32'(match_cnt), 32'd3);

    // Holdoff of 10 cycles swallows the match at t0+5
    wr("t2", 3'd4, 8'd2); wr("h10", 3'd5, 8'd10);
    cyc("armh", 0, 0, 0, 1, 0, 0);
    cyc("t0", 0, 0, 0, 0, 0, 1);
    idle("h_a", 4);
    cyc("t0p5", 0, 0, 0, 0, 0, 1);
    idle("h_b", 6);
    cyc("t0p12", 0, 0, 0, 0, 0, 1);
    check("holdoff_cnt", 32'(match_cnt), 32'd2);
    check("holdoff_trig", 32'(trig), 32'd1);

    // Write rejected while armed, accepted after disarm
    cyc("arm_rej", 0, 0, 0, 1, 0, 0);
    wr("wr_armed", 3'd0, 8'h45);
    check("rej_match_kept", 32'(match), 32'h00);
    cyc("disarm", 0, 0, 0, 0, 1, 0);
    wr("wr_open", 3'd0, 8'h45);
    check("match_45", 32'(match), 32'h45);

    // arm+disarm together, then UARTtrig with arm
    cyc("arm_x", 0, 0, 0, 1, 0, 0);
    cyc("arm_dis", 0, 0, 0, 1, 1, 0);
    check("both_disarmed", 32'(armed), 32'd0);
    cyc("arm_u", 0, 0, 0, 1, 0, 1);
    check("arm_u_cnt0", 32'(match_cnt), 32'd0);
    cyc("dis2", 0, 0, 0, 0, 1, 0);

    // Reset while in holdoff
    cyc("arm_r", 0, 0, 0, 1, 0, 0);
    cyc("u_r", 0, 0, 0, 0, 0, 1);
    check("in_holdoff_cnt", 32'(match_cnt), 32'd1);
    async_reset("rst_holdoff");

    // target = 0 acts as 1
    wr("t0v", 3'd4, 8'd0);
    cyc("arm0", 0, 0, 0, 1, 0, 0);
    cyc("u0", 0, 0, 0, 0, 0, 1);
    check("tgt0_trig", 32'(trig), 32'd1);
    idle("post0", 2);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit w, ar, da, u;
      logic [2:0] a;
      logic [7:0] d;
      w  = ($urandom_range(99) < 15);
      a  = 3'($urandom_range(7));
      d  = 8'($urandom);
      if (a == 3'd4) d = 8'($urandom_range(4));
      if (a == 3'd5) d = 8'($urandom_range(7));
      if (a == 3'd6) d = 8'($urandom_range(9) == 0 ? 1 : 0);
      ar = ($urandom_range(99) < 5);
      da = ($urandom_range(99) < 2);
      u  = ($urandom_range(99) < 25);
      cyc("rnd", w, a, d, ar, da, u);
      if (i == 1500) async_reset("rst_rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_trig_ctrl.md
Name: uart_trig_ctrl

Overview:
Configures and sequences the UART trigger receiver for the scope's trigger path.
- Holds the match, mask and baud_cnt configuration that drives the receiver.
- Arms and disarms trigger qualification.
- Counts qualifying UARTtrig matches up to a programmable occurrence count, with an optional holdoff between counted matches.
- Emits one trigger pulse to the capture logic.
- Locks configuration while armed, so the receiver's settings never change mid-acquisition.

Parameters:
- BAUD_RST, 16'd5208, reset value of baud_cnt (clock cycles per bit).
- MASK_RST, 8'hFF, reset value of mask (all bits don't-care).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wrt  in  1  config write strobe, one cycle
- addr  in  3  config register address
- wdata  in  8  config write data
- arm  in  1  arm request, one-cycle pulse
- disarm  in  1  disarm request, one-cycle pulse
- UARTtrig  in  1  match pulse from the UART trigger receiver
- baud_cnt  out  16  cycles per bit, to the receiver
- match  out  8  match pattern, to the receiver
- mask  out  8  don't-care mask, to the receiver
- armed  out  1  high in ARMED or HOLDOFF
- triggered  out  1  sticky, high in TRIGGERED
- trig  out  1  one-cycle pulse on the final qualifying match
- match_cnt  out  8  matches counted since the last arm
- wr_rej  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All state and outputs go to reset values immediately on rst_n low.
- Reset values:
  - state DISARMED
  - match 8'h00, mask MASK_RST, baud_cnt BAUD_RST
  - target 8'd1, holdoff 16'd0
  - match_cnt 0, trig 0, wr_rej 0, armed 0, triggered 0
- Register map (write-only, applied on wrt):
  - 0 match
  - 1 mask
  - 2 baud_cnt[7:0]
  - 3 baud_cnt[15:8]
  - 4 target
  - 5 holdoff[7:0]
  - 6 holdoff[15:8]
  - 7 reserved: write silently ignored, no wr_rej
- Write timing:
  - Writes take effect on the next clk edge and only in DISARMED or TRIGGERED.
  - A write in ARMED or HOLDOFF leaves every register unchanged and pulses wr_rej on the following cycle.
  - Byte halves of baud_cnt and holdoff update independently.
- target = 0 behaves as target = 1.
- State machine (states DISARMED, ARMED, HOLDOFF, TRIGGERED):
  - disarm in any state → DISARMED next cycle. match_cnt holds its value. No trig.
  - arm in DISARMED or TRIGGERED → ARMED. match_cnt cleared to 0.
  - arm in ARMED or HOLDOFF: ignored.
  - arm and disarm in the same cycle: disarm wins.
  - ARMED, UARTtrig high:
    - match_cnt increments (saturates at 8'hFF).
    - If the new count ≥ effective target: go to TRIGGERED and pulse trig the same cycle UARTtrig is sampled (registered, visible the cycle after).
    - Else if holdoff ≠ 0: go to HOLDOFF, loading the down-counter with holdoff.
    - Else: stay in ARMED.
  - HOLDOFF:
    - UARTtrig is ignored and not counted.
    - The counter decrements each cycle; at 1 → ARMED. Exactly holdoff cycles are spent in HOLDOFF.
  - TRIGGERED: sticky. Further UARTtrig is ignored. Leaves only via arm or disarm.
  - UARTtrig in DISARMED: ignored.
  - UARTtrig coincident with arm: not counted. Counting starts the cycle after entry to ARMED.
  - UARTtrig coincident with disarm: not counted, no trig.
- Output latency:
  - trig: exactly one cycle wide, asserted the cycle after the qualifying UARTtrig sample.
  - triggered: rises in the same cycle as trig.
  - armed, triggered: registered, decoded from the state register.
- Config outputs: baud_cnt, match and mask are driven straight from registers and are never glitched by FSM activity.

Test Plan:
- Reset, then read outputs → baud_cnt=5208, mask=8'hFF, match=0, armed=0, triggered=0. Write addr2=8'h10, addr3=8'h01 → baud_cnt=16'h0110.
- Set target=3, holdoff=0, arm; pulse UARTtrig on 3 separated cycles → match_cnt 1,2,3; single trig pulse after the third; triggered=1. A 4th UARTtrig → no change.
- Set target=2, holdoff=10; arm; UARTtrig at t0, t0+5, t0+12 → t0+5 ignored (HOLDOFF), match_cnt=2 and trig one cycle after t0+12.
- Arm, then write addr0=8'h45 → wr_rej pulse, match unchanged. Disarm, rewrite addr0=8'h45 → match=8'h45, no wr_rej.
- Assert arm and disarm together while ARMED → DISARMED. Assert UARTtrig coincident with arm from DISARMED → match_cnt stays 0.
- Assert rst_n low while in HOLDOFF with match_cnt=1 → immediate DISARMED and all reset values. target=0 with one UARTtrig after arm → trig.
